// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target
// and the controller that talks to it.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h21;
  localparam int         I2C_REG_DEPTH    = 256;

  function automatic logic [7:0] shift_in(
    input logic [7:0] v,
    input logic       b
  );
    return {v[6:0], b};
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clk_i domain and flags
// SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] scl_sync_q;
  logic [N-1:0] sda_sync_q;
  logic         scl_prev_q;
  logic         sda_prev_q;
  logic         scl_s;

  // Idle bus is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[N-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[N-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_o;
    end
  end

  assign scl_s = scl_sync_q[N-1];
  assign sda_o = sda_sync_q[N-1];

  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o = scl_s & scl_prev_q
                 & sda_prev_q & ~sda_o;
  assign stop_o  = scl_s & scl_prev_q
                 & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a 256 x 8 register file with an
// auto-incrementing register pointer.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_drive_o,
  output logic       wr_strobe_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [7:0] probe_addr_i,
  output logic [7:0] probe_data_o,
  output logic       busy_o
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_mon (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       drive_q, drive_d;
  logic       strb_q, strb_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       mem_we;
  logic [7:0] mem_q [I2C_REG_DEPTH];
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  assign rx_byte = shift_in(sh_q, sda_s);
  assign rd_byte = mem_q[ptr_q];

  // In the ACK states drive_q doubles as the phase marker:
  // first SCL fall asserts the ACK, the next one ends it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    drive_d = drive_q;
    strb_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WAIT_STOP: ;
        ST_ADDR: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              rw_d    = rx_byte[0];
              state_d = (rx_byte[7:1] == TARGET_ADDR)
                      ? ST_ADDR_ACK : ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!drive_q) begin
              drive_d = 1'b1;
            end else if (rw_q) begin
              state_d = ST_RDATA;
              sh_d    = rd_byte;
              drive_d = ~rd_byte[7];
              cnt_d   = '0;
            end else begin
              state_d = ST_REG;
              drive_d = 1'b0;
            end
          end
        end
        ST_REG: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              ptr_d   = rx_byte;
              state_d = ST_REG_ACK;
            end
          end
        end
        ST_REG_ACK: begin
          if (scl_fall) begin
            if (!drive_q) begin
              drive_d = 1'b1;
            end else begin
              drive_d = 1'b0;
              state_d = ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              mem_we  = 1'b1;
              strb_d  = 1'b1;
              waddr_d = ptr_q;
              wdata_d = rx_byte;
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!drive_q) begin
              drive_d = 1'b1;
            end else begin
              drive_d = 1'b0;
              ptr_d   = ptr_q + 8'd1;
              state_d = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = '0;
              drive_d = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              sh_d    = {sh_q[6:0], 1'b0};
              drive_d = ~sh_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_WAIT_STOP;
            end else begin
              ptr_d = ptr_q + 8'd1;
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = ST_RDATA;
            sh_d    = rd_byte;
            drive_d = ~rd_byte[7];
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      drive_q <= 1'b0;
      strb_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      drive_q <= drive_d;
      strb_q  <= strb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < I2C_REG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[ptr_q] <= wdata_d;
    end
  end

  assign sda_drive_o  = drive_q;
  assign wr_strobe_o  = strb_q;
  assign wr_addr_o    = waddr_q;
  assign wr_data_o    = wdata_q;
  assign probe_data_o = mem_q[probe_addr_i];
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, transaction-level
// register-file model, table vectors and random traffic.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_c = 1'b1;
  logic       sda_bus;
  logic       sda_drive;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] probe_addr = 8'h00;
  logic [7:0] probe_data;
  logic       busy;

  assign sda_bus = sda_c & ~sda_drive;

  i2c_target #(
    .TARGET_ADDR(7'h21),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_drive_o (sda_drive),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .probe_addr_i(probe_addr),
    .probe_data_o(probe_data),
    .busy_o      (busy)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] got_q[$];
  int          got_rd = 0;
  int          drv_cycles = 0;

  always @(negedge clk) begin
    if (!rst && wr_strobe) got_q.push_back({wr_addr, wr_data});
    if (sda_drive) drv_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: register file, pointer, expected strobes
  logic [7:0]  m_mem [256];
  logic [7:0]  m_ptr;
  logic [15:0] exp_q[$];
  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_ptr = 8'h00;
  endtask

  task automatic m_write(input logic [7:0] idx, input int n);
    m_ptr = idx;
    for (int i = 0; i < n; i++) begin
      m_mem[m_ptr] = wbuf[i];
      exp_q.push_back({m_ptr, wbuf[i]});
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    hw(8); sda_c = 1'b1; hw(8); scl = 1'b1;
    hw(16); sda_c = 1'b0; hw(16); scl = 1'b0;
  endtask

  task automatic bus_stop();
    hw(8); sda_c = 1'b0; hw(8); scl = 1'b1;
    hw(16); sda_c = 1'b1; hw(16);
  endtask

  task automatic send_bit(input logic b);
    hw(8); sda_c = b; hw(8); scl = 1'b1; hw(16); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    hw(8); sda_c = 1'b1; hw(8); scl = 1'b1;
    hw(8); b = sda_bus; hw(8); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(r);
      b[i] = r;
    end
    send_bit(~ack);
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [7:0] idx,
                          input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    write_byte({dev, 1'b0}, a); acks += int'(a);
    write_byte(idx, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a); acks += int'(a);
    end
    bus_stop();
  endtask

  task automatic do_read(input logic [6:0] dev, input int n,
                         output logic a);
    bus_start();
    write_byte({dev, 1'b1}, a);
    for (int i = 0; i < n; i++) read_byte(rbuf[i], i < n - 1);
    bus_stop();
  endtask

  task automatic probe_chk(input string nm, input logic [7:0] a);
    probe_addr = a;
    #1;
    chk(nm, probe_data, m_mem[a]);
  endtask

  task automatic check_strobes(input string nm);
    hw(2);
    chk({nm, " strobe count"}, got_q.size() - got_rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (got_rd + i < got_q.size())
        chk({nm, " strobe"}, got_q[got_rd + i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  typedef struct {
    logic [6:0] dev;
    logic [7:0] idx;
    logic [7:0] dat;
    logic       exp_ack;
  } vec_t;

  vec_t vt [6];

  initial begin
    int acks;
    int d0;
    logic a1, a2, a3;
    logic [7:0] b;
    logic [6:0] dev;
    logic [7:0] idx;
    int n;
    bit good;

    vt[0] = '{7'h21, 8'h05, 8'hA5, 1'b1};
    vt[1] = '{7'h20, 8'h06, 8'h5A, 1'b0};
    vt[2] = '{7'h21, 8'h00, 8'hFF, 1'b1};
    vt[3] = '{7'h61, 8'h07, 8'h3C, 1'b0};
    vt[4] = '{7'h21, 8'h7F, 8'h01, 1'b1};
    vt[5] = '{7'h23, 8'h05, 8'hEE, 1'b0};

    m_reset();
    hw(5);
    chk("reset sda_drive", sda_drive, 0);
    chk("reset wr_strobe", wr_strobe, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset busy", busy, 0);
    probe_chk("reset probe", 8'($urandom_range(0, 255)));
    hw(1); rst = 1'b0; hw(10);

    // Single write
    wbuf[0] = 8'h80;
    m_write(8'h12, 1);
    do_write(7'h21, 8'h12, 1, acks);
    chk("write acks", acks, 3);
    check_strobes("write");
    probe_chk("write probe 12", 8'h12);
    chk("write busy after stop", busy, 0);

    // Burst write across the pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    m_write(8'hFE, 3);
    do_write(7'h21, 8'hFE, 3, acks);
    chk("burst acks", acks, 5);
    check_strobes("burst");
    probe_chk("burst probe FE", 8'hFE);
    probe_chk("burst probe FF", 8'hFF);
    probe_chk("burst probe 00", 8'h00);

    // Index write, repeated START, single-byte read
    bus_start();
    write_byte(8'h42, a1);
    write_byte(8'h12, a2);
    m_ptr = 8'h12;
    chk("rd busy mid", busy, 1);
    bus_start();
    write_byte(8'h43, a3);
    read_byte(b, 1'b0);
    hw(8);
    chk("rd released after nack", sda_drive, 0);
    bus_stop();
    chk("rd acks", {a1, a2, a3}, 3'b111);
    chk("rd data", b, m_mem[m_ptr]);
    chk("rd busy after stop", busy, 0);
    check_strobes("rd");

    // Wrong address never drives and never writes
    d0 = drv_cycles;
    wbuf[0] = 8'h99;
    do_write(7'h30, 8'h44, 1, acks);
    chk("wrong addr acks", acks, 0);
    chk("wrong addr drive cycles", drv_cycles - d0, 0);
    check_strobes("wrong addr");
    probe_chk("wrong addr probe 44", 8'h44);

    // STOP after 4 data bits: index kept, no write
    bus_start();
    write_byte(8'h42, a1);
    write_byte(8'h30, a2);
    m_ptr = 8'h30;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop();
    chk("partial busy", busy, 0);
    check_strobes("partial");
    probe_chk("partial probe 30", 8'h30);
    do_read(7'h21, 1, a1);
    chk("partial then read data", rbuf[0], m_mem[8'h30]);

    // Reset while the target is driving the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h42 >> i));
    hw(8);
    chk("ack drive before reset", sda_drive, 1);
    #2 rst = 1'b1;
    #1 chk("async release on reset", sda_drive, 0);
    m_reset();
    hw(4);
    chk("reset busy mid", busy, 0);
    probe_chk("reset cleared 12", 8'h12);
    rst = 1'b0;
    hw(4); sda_c = 1'b1; hw(8); scl = 1'b1; hw(16);
    wbuf[0] = 8'hC3;
    m_write(8'h55, 1);
    do_write(7'h21, 8'h55, 1, acks);
    chk("post-reset acks", acks, 3);
    check_strobes("post-reset");
    probe_chk("post-reset probe 55", 8'h55);

    // Table vectors
    foreach (vt[k]) begin
      wbuf[0] = vt[k].dat;
      if (vt[k].exp_ack) m_write(vt[k].idx, 1);
      do_write(vt[k].dev, vt[k].idx, 1, acks);
      chk($sformatf("vec%0d acks", k), acks, vt[k].exp_ack ? 3 : 0);
      check_strobes($sformatf("vec%0d", k));
      probe_chk($sformatf("vec%0d probe", k), vt[k].idx);
    end

    // Random traffic against the model
    for (int t = 0; t < 20; t++) begin
      good = ($urandom_range(0, 4) != 0);
      dev = good ? 7'h21 : 7'($urandom_range(0, 127));
      if (!good && dev == 7'h21) dev = 7'h22;
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        idx = 8'($urandom_range(0, 255));
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        if (good) m_write(idx, n);
        do_write(dev, idx, n, acks);
        chk($sformatf("rnd%0d wr acks", t), acks, good ? n + 2 : 0);
        check_strobes($sformatf("rnd%0d", t));
      end else begin
        do_read(dev, n, a1);
        chk($sformatf("rnd%0d rd ack", t), a1, good);
        for (int i = 0; i < n; i++) begin
          if (good) begin
            chk($sformatf("rnd%0d rd%0d", t, i), rbuf[i], m_mem[m_ptr]);
            if (i < n - 1) m_ptr = m_ptr + 8'd1;
          end else begin
            chk($sformatf("rnd%0d rd%0d", t, i), rbuf[i], 8'hFF);
          end
        end
        check_strobes($sformatf("rnd%0d", t));
      end
      chk($sformatf("rnd%0d busy", t), busy, 0);
    end

    for (int i = 0; i < 256; i++)
      probe_chk($sformatf("final probe %0h", i), 8'(i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
